// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Purpose  : Single-port RV32I data memory behind a request/response
//             handshake. Performs byte/half/word lane steering on stores,
//             sign/zero extension on loads, a configurable read latency,
//             response backpressure and fault reporting (misaligned,
//             out-of-range, illegal funct3).
//  Ports    : clk_i         - clock, rising edge
//             reset_i       - synchronous active-high reset
//             req_valid_i   - request present
//             req_ready_o   - request can be accepted this cycle
//             req_we_i      - 1 = store, 0 = load
//             req_funct3_i  - RV32I width code (B/H/W/BU/HU)
//             req_addr_i    - byte address
//             req_wdata_i   - right-aligned store data
//             rsp_valid_o   - response present
//             rsp_ready_i   - consumer takes the response
//             rsp_rdata_o   - extended load data, 0 for stores/faults
//             rsp_err_o     - access faulted, memory unchanged
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] ld_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH];

  logic [31:0]   w_off;
  logic [1:0]    w_lane;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_f3_ok;
  logic          w_misal;
  logic [3:0]    w_be;
  logic          w_err;
  logic          w_accept;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;
  logic [31:0]   w_wdata_lane;

  // Address decode relative to the memory base
  assign w_off  = req_addr_i - BASE_ADDR;
  assign w_lane = w_off[1:0];
  assign w_idx  = w_off[AW+1:2];
  // Compare in 64 bits so DEPTH*4 cannot wrap
  assign w_oor  = (req_addr_i < BASE_ADDR) ||
                  ({32'b0, w_off} >= (64'(DEPTH) << 2));

  // Width decode: legality, alignment and store byte enables
  always_comb begin
    w_f3_ok = 1'b0;
    w_misal = 1'b0;
    w_be    = 4'b0000;
    case (req_funct3_i)
      3'b000: begin
        w_f3_ok = 1'b1;
        w_be    = 4'b0001 << w_lane;
      end
      3'b001: begin
        w_f3_ok = 1'b1;
        w_misal = w_lane[0];
        w_be    = 4'b0011 << w_lane;
      end
      3'b010: begin
        w_f3_ok = 1'b1;
        w_misal = |w_lane;
        w_be    = 4'b1111;
      end
      3'b100: begin
        w_f3_ok = ~req_we_i;  // unsigned widths exist for loads only
      end
      3'b101: begin
        w_f3_ok = ~req_we_i;
        w_misal = w_lane[0];
      end
      default: begin
        w_f3_ok = 1'b0;
      end
    endcase
  end

  assign w_err    = w_oor | ~w_f3_ok | w_misal;
  assign w_accept = req_valid_i & req_ready_o;

  // Load path: read the addressed word now and extract the selected lanes
  assign w_word  = mem_q[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_load = w_word;
    case (req_funct3_i)
      3'b000:  w_load = {{24{w_shift[7]}},  w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'b0, w_shift[7:0]};
      3'b101:  w_load = {16'b0, w_shift[15:0]};
      default: w_load = w_word;
    endcase
  end

  // Store path: move right-aligned data up to its byte lane
  assign w_wdata_lane = req_wdata_i << {w_lane, 3'b000};

  // Ready is gated by reset so nothing is accepted in the reset cycle
  assign req_ready_o = (state_q == IDLE) & ~reset_i;

  // Memory array, not reset; stores commit at the acceptance edge
  always_ff @(posedge clk_i) begin
    if (w_accept && req_we_i && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      ld_q        <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else if (req_we_i) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= 32'd0;
            end else if (RD_LATENCY <= 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= w_load;
            end else begin
              // Data is captured now; RD_WAIT only models the delay
              state_q <= RD_WAIT;
              cnt_q   <= 3'(RD_LATENCY - 1);
              ld_q    <= w_load;
            end
          end
        end
        RD_WAIT: begin
          // Leaving on count 1 lands RESP exactly RD_LATENCY cycles after acceptance
          if (cnt_q <= 3'd1) begin
            state_q     <= RESP;
            cnt_q       <= 3'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= ld_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised single-port data memory for the RV32I load/store stage, with a request/response handshake.
- Handles byte, half and word accesses at any legal byte offset: lane steering on stores, sign/zero extension on loads.
- Adds configurable read latency, backpressure on the response, and error reporting for misaligned, out-of-range and illegal-funct3 accesses.
- Sits between the execute/mem pipeline stage and the writeback mux.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of two, minimum 16.
- RD_LATENCY, 1, cycles from load acceptance to rsp_valid; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; memory unchanged.

Behaviour:
- Reset (synchronous, active-high): req_ready=0 during the reset cycle and 1 from the first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM to IDLE.
  - Memory contents are not cleared.
  - Reset mid-operation aborts any in-flight load or held response without emitting it.
  - A store accepted before reset has already committed.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE: req_ready=1. Handshake = req_valid & req_ready.
    - On an accepted store or any error: go to RESP next cycle.
    - On an accepted legal load: go to RD_WAIT with a latency counter set to RD_LATENCY-1. When RD_LATENCY=1, go directly to RESP.
  - RD_WAIT: req_ready=0. Decrement the counter; go to RESP when it reaches 0.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then return to IDLE.
  - No request can be accepted in the cycle a response completes; the next acceptance is one cycle later.
- Exactly one outstanding request at a time. A load is accepted to rsp_valid in RD_LATENCY cycles; a store is acknowledged with rsp_valid the cycle after acceptance.
- Addressing:
  - off = req_addr - BASE_ADDR.
  - word index = off[log2(DEPTH)+1:2].
  - lane = off[1:0].
  - Out of range when req_addr < BASE_ADDR or off >= DEPTH*4.
- Error conditions, checked at acceptance; any one sets rsp_err=1, rsp_rdata=0, no write:
  - half access with lane[0]=1;
  - word access with lane!=0;
  - out of range;
  - funct3 not in the list above;
  - store with funct3 100 or 101.
- Store, committed at the acceptance edge using byte enables:
  - SB writes byte lane `lane` with wdata[7:0].
  - SH writes lanes {lane+1, lane} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected bytes are preserved.
- Load: the memory word is read at acceptance and the selected lane(s) are extracted.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Data is captured at acceptance, so a later store cannot alter an in-flight load (only one outstanding anyway).
- Stability: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs are unchanged every cycle.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with RD_LATENCY=1 -> store rsp_valid 1 cycle after accept with err=0, rdata=0; load rsp_rdata=0xDEADBEEF exactly 1 cycle after accept.
- SB 0x11 data 0x7F, then LB 0x11, LB 0x13, LBU 0x13, LH 0x12, LHU 0x12 -> 0x0000007F, 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD; LW 0x10 = 0xDEAD7FEF.
- SH 0x13, LW 0x12, LB with funct3 011, SB to byte address DEPTH*4 -> each rsp_err=1, rdata=0; a subsequent LW 0x10 still returns 0xDEAD7FEF.
- RD_LATENCY=3, LW accepted at cycle t -> rsp_valid first high at t+3; req_ready low for cycles t+1..t+3 and until the response handshake.
- Hold rsp_ready=0 for 5 cycles after a load response -> rsp_valid, rsp_rdata, rsp_err constant; req_ready=0; a pending req_valid is not accepted until one cycle after rsp_ready=1.
- Assert reset in the RD_WAIT cycle of an LW (RD_LATENCY=3) -> no rsp_valid ever for that load; req_ready=1 the cycle after reset deasserts; memory contents retained.
